// File: rtl/alu_issue_if.sv
// Request, ALU-drive and response signal bundle for alu_issue.
// master = decode/ALU/writeback side, slave = the sequencer itself.
interface alu_issue_if #(
    parameter int IMM_W     = 16,
    parameter int ERR_CNT_W = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [3:0]           req_funct;
    logic [31:0]          req_a;
    logic [31:0]          req_b;
    logic                 req_use_imm;
    logic [IMM_W-1:0]     req_imm;
    logic [4:0]           req_rd;

    logic [3:0]           alu_op;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [31:0]          alu_result;
    logic                 alu_zero;
    logic                 alu_unknown_op;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_result;
    logic                 rsp_zero;
    logic [4:0]           rsp_rd;
    logic                 rsp_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output req_valid, req_funct, req_a, req_b, req_use_imm, req_imm, req_rd,
        output alu_result, alu_zero, alu_unknown_op, rsp_ready,
        input  req_ready, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_result, rsp_zero, rsp_rd, rsp_err, err_cnt
    );

    modport slave (
        input  req_valid, req_funct, req_a, req_b, req_use_imm, req_imm, req_rd,
        input  alu_result, alu_zero, alu_unknown_op, rsp_ready,
        output req_ready, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_result, rsp_zero, rsp_rd, rsp_err, err_cnt
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/retire sequencer: S1 registers decoded op onto the ALU, S2 captures the result; 2-cycle latency, 1 op/cycle.
// Backpressure: !rsp_ready holds S2, S1 holds behind it, req_ready drops once both are full; flush empties both.
module alu_issue #(
    parameter int IMM_W     = 16,
    parameter int ERR_CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    alu_issue_if.slave bus
);
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_EQ  = 4'h4;
    localparam logic [3:0] ALU_NOP = 4'hF;

    logic                 s1_valid;
    logic [3:0]           s1_op;
    logic [31:0]          s1_a;
    logic [31:0]          s1_b;
    logic [4:0]           s1_rd;
    logic                 s1_illegal;

    logic                 s2_valid;
    logic [31:0]          s2_result;
    logic                 s2_zero;
    logic [4:0]           s2_rd;
    logic                 s2_err;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic [3:0]           dec_op;
    logic                 dec_illegal;
    logic [31:0]          dec_b;
    logic                 s2_free;
    logic                 s1_adv;
    logic                 req_rdy;
    logic                 accept;
    logic                 rsp_hs;
    logic                 cap_err;

    always_comb begin
        dec_op      = ALU_NOP;
        dec_illegal = 1'b0;
        case (bus.req_funct)
            4'd0:    dec_op = ALU_AND;
            4'd1:    dec_op = ALU_OR;
            4'd2:    dec_op = ALU_ADD;
            4'd3:    dec_op = ALU_SUB;
            4'd4:    dec_op = ALU_EQ;
            4'd5:    dec_op = ALU_NOP;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_b   = bus.req_use_imm ? {{(32-IMM_W){bus.req_imm[IMM_W-1]}}, bus.req_imm}
                                     : bus.req_b;
    assign s2_free = !s2_valid || bus.rsp_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign req_rdy = !flush && (!s1_valid || s2_free);
    assign accept  = bus.req_valid && req_rdy;
    assign rsp_hs  = s2_valid && bus.rsp_ready;
    assign cap_err = s1_illegal || bus.alu_unknown_op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_op      <= ALU_NOP;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_rd      <= '0;
            s1_illegal <= 1'b0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_rd      <= '0;
            s2_err     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            // Retirement is counted even in a flush cycle; the counter survives flush.
            if (rsp_hs && s2_err && (err_cnt_q != {ERR_CNT_W{1'b1}}))
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);

            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s1_adv) begin
                    s2_valid  <= 1'b1;
                    s2_result <= cap_err ? 32'd0 : bus.alu_result;
                    s2_zero   <= !cap_err && bus.alu_zero;
                    s2_rd     <= s1_rd;
                    s2_err    <= cap_err;
                end else if (rsp_hs) begin
                    s2_valid <= 1'b0;
                end

                if (accept) begin
                    s1_valid   <= 1'b1;
                    s1_op      <= dec_op;
                    s1_a       <= bus.req_a;
                    s1_b       <= dec_b;
                    s1_rd      <= bus.req_rd;
                    s1_illegal <= dec_illegal;
                end else if (s1_adv) begin
                    s1_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready  = req_rdy;
    assign bus.alu_op     = s1_op;
    assign bus.alu_a      = s1_a;
    assign bus.alu_b      = s1_b;
    assign bus.rsp_valid  = s2_valid;
    assign bus.rsp_result = s2_result;
    assign bus.rsp_zero   = s2_zero;
    assign bus.rsp_rd     = s2_rd;
    assign bus.rsp_err    = s2_err;
    assign bus.err_cnt    = err_cnt_q;
endmodule
